wb_arbiter: RTL

Writeback arbiter that shares the single register-file write port among the ALU, MUL and LSU completion streams. Each unit hands its finished result (rd, data) to a one-entry holding buffer. The arbiter grants one buffer per cycle and drives a registered write port. In the same cycle it sends a clear pulse with the tag to the scoreboard, which releases the busy status of that destination register.

---
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three one-entry result buffers (ALU/MUL/LSU) share one registered regfile write port.
// Define WB_RR_EN for round-robin arbitration; default is fixed priority LSU > MUL > ALU.
module wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [RA-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mul_valid,
  input  logic [RA-1:0]   mul_rd,
  input  logic [XLEN-1:0] mul_data,
  output logic            mul_ready,
  input  logic            lsu_valid,
  input  logic [RA-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            wb_hold,
  output logic            wb_en,
  output logic [RA-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      wb_src,
  output logic            sb_clr,
  output logic [RA-1:0]   sb_clr_rd
);

  localparam int unsigned NU = 3;

  // Unit index: 0 ALU, 1 MUL, 2 LSU
  logic [NU-1:0]   in_valid;
  logic [RA-1:0]   in_rd    [NU];
  logic [XLEN-1:0] in_data  [NU];
  logic [NU-1:0]   full;
  logic [RA-1:0]   buf_rd   [NU];
  logic [XLEN-1:0] buf_data [NU];
  logic [NU-1:0]   grant;
  logic [NU-1:0]   ready;
  logic [RA-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [1:0]      sel_src;

  assign in_valid   = {lsu_valid, mul_valid, alu_valid};
  assign in_rd[0]   = alu_rd;
  assign in_rd[1]   = mul_rd;
  assign in_rd[2]   = lsu_rd;
  assign in_data[0] = alu_data;
  assign in_data[1] = mul_data;
  assign in_data[2] = lsu_data;

  // One-hot of the first full buffer in the order a, b, c
  function automatic logic [NU-1:0] pick(input logic [NU-1:0] f,
                                         input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
    logic [NU-1:0] g;
    g = '0;
    if (f[a])      g[a] = 1'b1;
    else if (f[b]) g[b] = 1'b1;
    else if (f[c]) g[c] = 1'b1;
    return g;
  endfunction

`ifdef WB_RR_EN
  logic [1:0] ptr;

  always_comb begin
    grant = '0;
    if (!wb_hold) begin
      case (ptr)
        2'd0:    grant = pick(full, 2'd1, 2'd2, 2'd0);
        2'd1:    grant = pick(full, 2'd2, 2'd0, 2'd1);
        default: grant = pick(full, 2'd0, 2'd1, 2'd2);
      endcase
    end
  end

  // Pointer remembers the last granted unit; reset value LSU gives ALU first turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd2;
    end else if (|grant) begin
      ptr <= grant[0] ? 2'd0 : (grant[1] ? 2'd1 : 2'd2);
    end
  end
`else
  always_comb begin
    grant = '0;
    if (!wb_hold) grant = pick(full, 2'd2, 2'd1, 2'd0);
  end
`endif

  // Grant depends only on state and hold, so ready has no path from valid
  assign ready     = ~full | grant;
  assign alu_ready = ready[0];
  assign mul_ready = ready[1];
  assign lsu_ready = ready[2];

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    sel_src  = 2'b00;
    for (int i = 0; i < NU; i++) begin
      if (grant[i]) begin
        sel_rd   = buf_rd[i];
        sel_data = buf_data[i];
        sel_src  = 2'(i + 1);
      end
    end
  end

  // Buffers: a same-edge refill takes precedence over the drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < NU; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NU; i++) begin
        if (in_valid[i] && ready[i]) begin
          full[i]     <= 1'b1;
          buf_rd[i]   <= in_rd[i];
          buf_data[i] <= in_data[i];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Write port and scoreboard clear; x0 writes are suppressed but still clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_src    <= 2'b00;
      sb_clr    <= 1'b0;
      sb_clr_rd <= '0;
    end else if (|grant) begin
      wb_en     <= (sel_rd != '0);
      wb_rd     <= sel_rd;
      wb_data   <= sel_data;
      wb_src    <= sel_src;
      sb_clr    <= 1'b1;
      sb_clr_rd <= sel_rd;
    end else begin
      wb_en  <= 1'b0;
      wb_src <= 2'b00;
      sb_clr <= 1'b0;
    end
  end

endmodule
